// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin share of one combinational ALU between two requesters,
// with a one-entry registered result stage tagged by source and transaction tag
module alu_share_arbiter #(
  parameter int TAG_W   = 4,
  parameter bit RST_PTR = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             r0_valid,
  output logic             r0_ready,
  input  logic [31:0]      r0_op1,
  input  logic [31:0]      r0_op2,
  input  logic [31:0]      r0_imm,
  input  logic [6:0]       r0_opcode,
  input  logic [2:0]       r0_func3,
  input  logic [6:0]       r0_func7,
  input  logic [TAG_W-1:0] r0_tag,
  input  logic             r1_valid,
  output logic             r1_ready,
  input  logic [31:0]      r1_op1,
  input  logic [31:0]      r1_op2,
  input  logic [31:0]      r1_imm,
  input  logic [6:0]       r1_opcode,
  input  logic [2:0]       r1_func3,
  input  logic [6:0]       r1_func7,
  input  logic [TAG_W-1:0] r1_tag,
  output logic [31:0]      alu_op1,
  output logic [31:0]      alu_op2,
  output logic [31:0]      alu_imm,
  output logic [6:0]       alu_opcode,
  output logic [2:0]       alu_func3,
  output logic [6:0]       alu_func7,
  input  logic [31:0]      alu_result,
  input  logic             alu_carry,
  input  logic             alu_zero,
  input  logic             alu_neg,
  input  logic             alu_ovf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [3:0]       out_flags,
  output logic             out_src,
  output logic [TAG_W-1:0] out_tag
);
  logic last_q, slot_free, g0, g1;
  assign slot_free = !out_valid | out_ready;
  // under contention the requester that did not win last time is granted
  assign g0 = r0_valid & (!r1_valid | last_q);
  assign g1 = r1_valid & (!r0_valid | !last_q);
  assign r0_ready = g0 & slot_free & !rst;
  assign r1_ready = g1 & slot_free & !rst;
  assign alu_op1    = g0 ? r0_op1    : g1 ? r1_op1    : '0;
  assign alu_op2    = g0 ? r0_op2    : g1 ? r1_op2    : '0;
  assign alu_imm    = g0 ? r0_imm    : g1 ? r1_imm    : '0;
  assign alu_opcode = g0 ? r0_opcode : g1 ? r1_opcode : '0;
  assign alu_func3  = g0 ? r0_func3  : g1 ? r1_func3  : '0;
  assign alu_func7  = g0 ? r0_func7  : g1 ? r1_func7  : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_flags  <= '0;
      out_src    <= 1'b0;
      out_tag    <= '0;
      last_q     <= RST_PTR;
    end else if (r0_ready | r1_ready) begin
      out_valid  <= 1'b1;
      out_result <= alu_result;
      out_flags  <= {alu_carry, alu_zero, alu_neg, alu_ovf};
      out_src    <= r1_ready;
      out_tag    <= r1_ready ? r1_tag : r0_tag;
      last_q     <= r1_ready;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed table, SLTU back-to-back sequence and randomized run against a behavioural model
module tb_alu_share_arbiter;
  localparam int TW = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic r0_valid, r0_ready, r1_valid, r1_ready;
  logic [31:0] r0_op1, r0_op2, r0_imm, r1_op1, r1_op2, r1_imm;
  logic [6:0] r0_opcode, r0_func7, r1_opcode, r1_func7;
  logic [2:0] r0_func3, r1_func3;
  logic [TW-1:0] r0_tag, r1_tag;
  logic [31:0] alu_op1, alu_op2, alu_imm, alu_result;
  logic [6:0] alu_opcode, alu_func7;
  logic [2:0] alu_func3;
  logic alu_carry, alu_zero, alu_neg, alu_ovf;
  logic out_valid, out_ready, out_src;
  logic [31:0] out_result;
  logic [3:0] out_flags;
  logic [TW-1:0] out_tag;
  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.TAG_W(TW), .RST_PTR(1'b1)) dut (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_op1(r0_op1), .r0_op2(r0_op2), .r0_imm(r0_imm),
    .r0_opcode(r0_opcode), .r0_func3(r0_func3), .r0_func7(r0_func7), .r0_tag(r0_tag),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_op1(r1_op1), .r1_op2(r1_op2), .r1_imm(r1_imm),
    .r1_opcode(r1_opcode), .r1_func3(r1_func3), .r1_func7(r1_func7), .r1_tag(r1_tag),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_imm(alu_imm), .alu_opcode(alu_opcode),
    .alu_func3(alu_func3), .alu_func7(alu_func7), .alu_result(alu_result),
    .alu_carry(alu_carry), .alu_zero(alu_zero), .alu_neg(alu_neg), .alu_ovf(alu_ovf),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_flags(out_flags), .out_src(out_src), .out_tag(out_tag)
  );

  // behavioural R-type ALU: {result, carry, zero, neg, ovf}; compares use the subtractor
  function automatic logic [35:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] f3, input logic [6:0] f7);
    logic [32:0] s;
    logic [31:0] r;
    logic sub, ov;
    sub = !(f3 == 3'd0 && !f7[5]);
    s = sub ? {1'b0, a} - {1'b0, b} : {1'b0, a} + {1'b0, b};
    ov = sub ? (a[31] != b[31]) && (s[31] != a[31]) : (a[31] == b[31]) && (s[31] != a[31]);
    case (f3)
      3'd0: r = s[31:0];
      3'd1: r = a << b[4:0];
      3'd2: r = {31'b0, $signed(a) < $signed(b)};
      3'd3: r = {31'b0, a < b};
      3'd4: r = a ^ b;
      3'd5: if (f7[5]) r = $signed(a) >>> b[4:0]; else r = a >> b[4:0];
      3'd6: r = a | b;
      default: r = a & b;
    endcase
    return {r, s[32], r == 32'd0, r[31], ov};
  endfunction

  assign {alu_result, alu_carry, alu_zero, alu_neg, alu_ovf} = alu_fn(alu_op1, alu_op2, alu_func3, alu_func7);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic rs, v0, v1, ordy, e0, e1;
    logic [31:0] ealu;
    logic eov, esrc;
    logic [3:0] etag;
    logic [31:0] eres;
    logic [3:0] efl;
  } vec_t;
  vec_t tv[16];

  function automatic vec_t mk(input logic rs, v0, v1, ordy, e0, e1, input logic [31:0] ealu,
                              input logic eov, esrc, input logic [3:0] etag,
                              input logic [31:0] eres, input logic [3:0] efl);
    vec_t v;
    v.rs = rs; v.v0 = v0; v.v1 = v1; v.ordy = ordy; v.e0 = e0; v.e1 = e1; v.ealu = ealu;
    v.eov = eov; v.esrc = esrc; v.etag = etag; v.eres = eres; v.efl = efl;
    return v;
  endfunction

  // random-phase requester state and model
  logic pv[2];
  logic [31:0] pa[2], pb[2], pi[2];
  logic [2:0] pf3[2];
  logic [6:0] pf7[2];
  logic [TW-1:0] pt[2];
  logic m_v, m_src, m_last;
  logic [TW-1:0] m_tag;
  logic [31:0] m_res;
  logic [3:0] m_fl;

  task automatic drive();
    r0_valid = pv[0]; r0_op1 = pa[0]; r0_op2 = pb[0]; r0_imm = pi[0]; r0_opcode = 7'h33;
    r0_func3 = pf3[0]; r0_func7 = pf7[0]; r0_tag = pt[0];
    r1_valid = pv[1]; r1_op1 = pa[1]; r1_op2 = pb[1]; r1_imm = pi[1]; r1_opcode = 7'h33;
    r1_func3 = pf3[1]; r1_func7 = pf7[1]; r1_tag = pt[1];
  endtask

  initial begin
    logic [35:0] f;
    logic acc, hs0, hs1;
    int g;
    r0_valid = 0; r1_valid = 0; out_ready = 1;
    r0_op1 = 32'd5; r0_op2 = 32'd7; r0_imm = 32'h0; r0_opcode = 7'h33; r0_func3 = 3'd0; r0_func7 = 7'h00; r0_tag = 4'd3;
    r1_op1 = 32'h10; r1_op2 = 32'h10; r1_imm = 32'h4; r1_opcode = 7'h33; r1_func3 = 3'd0; r1_func7 = 7'h20; r1_tag = 4'd9;
    @(posedge clk); #1;
    tv[0]  = mk(1, 1, 1, 1, 0, 0, 32'd5,  0, 0, 4'd0, 32'd0,  4'b0000);
    tv[1]  = mk(0, 1, 0, 1, 1, 0, 32'd5,  1, 0, 4'd3, 32'd12, 4'b0000);
    tv[2]  = mk(0, 0, 1, 1, 0, 1, 32'h10, 1, 1, 4'd9, 32'd0,  4'b0100);
    tv[3]  = mk(0, 1, 1, 1, 1, 0, 32'd5,  1, 0, 4'd3, 32'd12, 4'b0000);
    tv[4]  = mk(0, 1, 1, 1, 0, 1, 32'h10, 1, 1, 4'd9, 32'd0,  4'b0100);
    tv[5]  = tv[3];
    tv[6]  = tv[4];
    tv[7]  = mk(0, 1, 1, 0, 0, 0, 32'd5,  1, 1, 4'd9, 32'd0,  4'b0100);
    tv[8]  = tv[7];
    tv[9]  = tv[7];
    tv[10] = tv[3];
    tv[11] = mk(1, 1, 1, 0, 0, 0, 32'h10, 0, 0, 4'd0, 32'd0,  4'b0000);
    tv[12] = tv[3];
    tv[13] = mk(0, 0, 0, 1, 0, 0, 32'd0,  0, 0, 4'd3, 32'd12, 4'b0000);
    tv[14] = mk(0, 0, 1, 0, 0, 1, 32'h10, 1, 1, 4'd9, 32'd0,  4'b0100);
    tv[15] = mk(0, 1, 0, 0, 0, 0, 32'd5,  1, 1, 4'd9, 32'd0,  4'b0100);
    for (int i = 0; i < 16; i++) begin
      rst = tv[i].rs; r0_valid = tv[i].v0; r1_valid = tv[i].v1; out_ready = tv[i].ordy;
      #1;
      chk($sformatf("t%0d r0_ready", i), 32'(r0_ready), 32'(tv[i].e0));
      chk($sformatf("t%0d r1_ready", i), 32'(r1_ready), 32'(tv[i].e1));
      chk($sformatf("t%0d alu_op1", i), alu_op1, tv[i].ealu);
      @(posedge clk); #1;
      chk($sformatf("t%0d out_valid", i), 32'(out_valid), 32'(tv[i].eov));
      chk($sformatf("t%0d out_src", i), 32'(out_src), 32'(tv[i].esrc));
      chk($sformatf("t%0d out_tag", i), 32'(out_tag), 32'(tv[i].etag));
      chk($sformatf("t%0d out_result", i), out_result, tv[i].eres);
      chk($sformatf("t%0d out_flags", i), 32'(out_flags), 32'(tv[i].efl));
    end
    // back-to-back SLTU from r0 with no bubble
    rst = 0; r1_valid = 0; out_ready = 1; r0_valid = 1;
    r0_func3 = 3'd3; r0_func7 = 7'h00; r0_op1 = 32'h1; r0_op2 = 32'hFFFF_FFFF; r0_tag = 4'd5;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("sltu%0d r0_ready", i), 32'(r0_ready), 32'd1);
      @(posedge clk); #1;
      chk($sformatf("sltu%0d out_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("sltu%0d out_result", i), out_result, 32'd1);
      chk($sformatf("sltu%0d out_tag", i), 32'(out_tag), 32'd5);
    end
    // randomized run against the model
    pv[0] = 0; pv[1] = 0;
    for (int k = 0; k < 2; k++) begin
      pa[k] = 0; pb[k] = 0; pi[k] = 0; pf3[k] = 0; pf7[k] = 0; pt[k] = 0;
    end
    rst = 1; drive();
    @(posedge clk); #1;
    m_v = 0; m_src = 0; m_last = 1; m_tag = 0; m_res = 0; m_fl = 0;
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 59) == 0);
      for (int k = 0; k < 2; k++)
        if (!pv[k] && $urandom_range(0, 9) < 6) begin
          pv[k] = 1; pa[k] = $urandom;
          pb[k] = ($urandom_range(0, 3) == 0) ? pa[k] : $urandom;
          pf3[k] = 3'($urandom_range(0, 7));
          pf7[k] = ((pf3[k] == 3'd0 || pf3[k] == 3'd5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
          pt[k] = TW'($urandom); pi[k] = $urandom;
        end
      out_ready = ($urandom_range(0, 9) < 7);
      drive();
      #1;
      g = (pv[0] && pv[1]) ? (m_last ? 0 : 1) : pv[0] ? 0 : pv[1] ? 1 : -1;
      acc = (g >= 0) && (!m_v || out_ready) && !rst;
      chk("rnd r0_ready", 32'(r0_ready), 32'(acc && g == 0));
      chk("rnd r1_ready", 32'(r1_ready), 32'(acc && g == 1));
      chk("rnd alu_op1", alu_op1, g >= 0 ? pa[g] : 32'd0);
      chk("rnd alu_op2", alu_op2, g >= 0 ? pb[g] : 32'd0);
      chk("rnd alu_imm", alu_imm, g >= 0 ? pi[g] : 32'd0);
      chk("rnd alu_f3f7op", {15'b0, alu_opcode, alu_func3, alu_func7},
          g >= 0 ? {15'b0, 7'h33, pf3[g], pf7[g]} : 32'd0);
      hs0 = r0_valid & r0_ready;
      hs1 = r1_valid & r1_ready;
      @(posedge clk); #1;
      if (rst) begin
        m_v = 0; m_src = 0; m_last = 1; m_tag = 0; m_res = 0; m_fl = 0;
      end else if (acc) begin
        f = alu_fn(pa[g], pb[g], pf3[g], pf7[g]);
        m_v = 1; m_src = (g == 1); m_last = (g == 1); m_tag = pt[g]; m_res = f[35:4]; m_fl = f[3:0];
      end else if (out_ready) m_v = 0;
      if (hs0) pv[0] = 0;
      if (hs1) pv[1] = 0;
      chk("rnd out_valid", 32'(out_valid), 32'(m_v));
      chk("rnd out_src", 32'(out_src), 32'(m_src));
      chk("rnd out_tag", 32'(out_tag), 32'(m_tag));
      chk("rnd out_result", out_result, m_res);
      chk("rnd out_flags", 32'(out_flags), 32'(m_fl));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
